spi_slave: RTL and testbench

Byte-oriented SPI slave: the responder end of the team's SPI master. It receives MOSI bytes MSB-first and returns one byte per transfer on MISO. It sits between the external SPI pins and the AES datapath, delivering received key/plaintext bytes and accepting result bytes for transmission. All pin inputs are oversampled on the system clock; no logic runs on `sclk`.

---
 rtl/spi_slave.sv | 172 +++++++++++++++++
 tb/tb_spi_slave.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// Byte-oriented SPI slave (mode 0 style: master samples while sclk is high, slave shifts on the fall).
// Every pin is oversampled on clk; one-byte transmit buffer feeds the MISO shifter at byte boundaries.
module spi_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs,
    input  logic       sclk,
    input  logic       mosi,
    output logic       miso,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_underrun,
    output logic       busy
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_cs_prev;
    logic                   r_sclk_prev;

    logic       w_cs_s;
    logic       w_sclk_s;
    logic       w_mosi_s;
    logic       w_cs_fall;
    logic       w_cs_rise;
    logic       w_sclk_fall;

    logic [2:0] r_bit_cnt;
    logic [6:0] r_rx_shift;
    logic [7:0] r_tx_shift;
    logic [7:0] r_buf;
    logic       r_buf_full;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_underrun;

    logic       w_load;
    logic       w_shift;
    logic       w_byte_done;
    logic       w_abort;
    logic       w_wr;

    // The cs chain resets high so a pin already held low still produces a clean falling edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cs_sync   <= '1;
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_cs_prev   <= 1'b1;
            r_sclk_prev <= 1'b0;
        end else begin
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_cs_prev   <= w_cs_s;
            r_sclk_prev <= w_sclk_s;
        end
    end

    assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
    assign w_cs_fall   = r_cs_prev & ~w_cs_s;
    assign w_cs_rise   = ~r_cs_prev & w_cs_s;
    assign w_sclk_fall = r_sclk_prev & ~w_sclk_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A cs rise takes priority over a coincident sclk fall, so a late edge never captures a bit.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_byte_done = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cs_fall) begin
                    w_state_nxt = ST_ACTIVE;
                    w_load      = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (w_cs_rise) begin
                    w_state_nxt = ST_IDLE;
                    w_abort     = 1'b1;
                end else if (w_sclk_fall) begin
                    w_shift = 1'b1;
                    if (r_bit_cnt == 3'd7) begin
                        w_byte_done = 1'b1;
                        w_load      = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // tx_ready is the empty flag, so a write coinciding with a load lands only in an already-empty slot.
    assign w_wr = tx_valid & ~r_buf_full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_buf      <= 8'h00;
            r_buf_full <= 1'b0;
        end else if (w_wr) begin
            r_buf      <= tx_data;
            r_buf_full <= 1'b1;
        end else if (w_load) begin
            r_buf_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bit_cnt  <= 3'd0;
            r_rx_shift <= 7'h00;
            r_tx_shift <= 8'h00;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_rx_valid <= w_byte_done;
            r_underrun <= w_load & ~r_buf_full;
            if (w_abort) begin
                r_bit_cnt  <= 3'd0;
                r_rx_shift <= 7'h00;
                r_tx_shift <= 8'h00;
            end else if (w_shift) begin
                r_rx_shift <= {r_rx_shift[5:0], w_mosi_s};
                if (w_byte_done) begin
                    r_rx_data <= {r_rx_shift, w_mosi_s};
                    r_bit_cnt <= 3'd0;
                end else begin
                    r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                    r_bit_cnt  <= r_bit_cnt + 3'd1;
                end
            end
            if (w_load) begin
                r_tx_shift <= r_buf_full ? r_buf : 8'h00;
            end
        end
    end

    assign miso        = (r_state == ST_ACTIVE) & r_tx_shift[7];
    assign tx_ready    = ~r_buf_full;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign tx_underrun = r_underrun;
    assign busy        = ~w_cs_s;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: bit-banged SPI master, queue-based model of the
// one-byte transmit buffer, and a monitor that collects rx bytes and underrun pulses.
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       reset;
    logic       cs;
    logic       sclk;
    logic       mosi;
    logic       miso;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_underrun;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    spi_slave #(.SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun), .busy(busy)
    );

    // Observed traffic
    logic [7:0] rx_got[$];
    int         rx_long = 0;
    int         und_cnt = 0;
    logic       rx_prev = 1'b0;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            rx_got.push_back(rx_data);
            if (rx_prev === 1'b1) rx_long++;
        end
        rx_prev = rx_valid;
        if (tx_underrun === 1'b1) und_cnt++;
    end

    // Reference model: buffer as a queue of at most one byte; every byte load pops it or yields 0x00.
    logic [7:0] mdl_buf[$];
    int         mdl_und = 0;
    logic [7:0] exp_rx[$];

    function automatic logic [7:0] mdl_load();
        if (mdl_buf.size() != 0) return mdl_buf.pop_front();
        mdl_und++;
        return 8'h00;
    endfunction

    task automatic wr_tx(input logic [7:0] b);
        int   t = 0;
        logic exp_rdy;
        exp_rdy = (mdl_buf.size() == 0);
        checks++;
        if (tx_ready !== exp_rdy) begin
            failures++;
            $display("FAIL tx_ready_before_write got=%b exp=%b", tx_ready, exp_rdy);
        end
        while (tx_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (tx_ready !== 1'b1) begin
            failures++;
            $display("FAIL tx_write_timeout got=%b exp=1", tx_ready);
        end else begin
            tx_valid = 1'b1;
            tx_data  = b;
            @(negedge clk);
            tx_valid = 1'b0;
            mdl_buf.push_back(b);
            checks++;
            if (tx_ready !== 1'b0) begin
                failures++;
                $display("FAIL tx_ready_after_write got=%b exp=0", tx_ready);
            end
        end
    endtask

    task automatic cs_fall();
        cs = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic cs_rise();
        repeat (2) @(negedge clk);
        cs = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // Clocks n bits MSB-first; optionally refills the buffer at the start of bit 4.
    task automatic spi_bits(input int n, input logic [7:0] mo, output logic [7:0] mi,
                            input bit do_feed, input logic [7:0] fv);
        mi = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            if (do_feed && i == 4) wr_tx(fv);
            mosi = mo[i];
            repeat (4) @(negedge clk);
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            mi[i] = miso;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
            repeat (4) @(negedge clk);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
        tx_valid = 1'b0; tx_data = 8'h00;
        repeat (3) @(negedge clk);
        checks++; if (miso !== 1'b0)        begin failures++; $display("FAIL rst_miso got=%b exp=0", miso); end
        checks++; if (rx_data !== 8'h00)    begin failures++; $display("FAIL rst_rx_data got=%h exp=00", rx_data); end
        checks++; if (rx_valid !== 1'b0)    begin failures++; $display("FAIL rst_rx_valid got=%b exp=0", rx_valid); end
        checks++; if (tx_ready !== 1'b1)    begin failures++; $display("FAIL rst_tx_ready got=%b exp=1", tx_ready); end
        checks++; if (tx_underrun !== 1'b0) begin failures++; $display("FAIL rst_underrun got=%b exp=0", tx_underrun); end
        checks++; if (busy !== 1'b0)        begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        reset = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (busy !== 1'b0 || tx_ready !== 1'b1) begin
            failures++; $display("FAIL post_rst_idle busy=%b tx_ready=%b exp busy=0 tx_ready=1", busy, tx_ready);
        end
    endtask

    task automatic test_basic();
        logic [7:0] mi, e;
        int u0 = und_cnt, m0 = mdl_und;
        wr_tx(8'hA5);
        cs_fall();
        e = mdl_load();
        checks++; if (busy !== 1'b1)     begin failures++; $display("FAIL basic_busy got=%b exp=1", busy); end
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL basic_ready_after_load got=%b exp=1", tx_ready); end
        spi_bits(8, 8'h3C, mi, 1'b0, 8'h00);
        exp_rx.push_back(8'h3C);
        void'(mdl_load());
        cs_rise();
        checks++; if (mi !== e) begin failures++; $display("FAIL basic_miso got=%h exp=%h", mi, e); end
        checks++; if (rx_got.size() != 1 || rx_got[0] !== 8'h3C) begin
            failures++; $display("FAIL basic_rx count=%0d exp_count=1 data=%h exp=3c", rx_got.size(), rx_data);
        end
        checks++; if (rx_data !== 8'h3C) begin failures++; $display("FAIL basic_rx_data_stable got=%h exp=3c", rx_data); end
        checks++; if ((und_cnt - u0) != (mdl_und - m0)) begin
            failures++; $display("FAIL basic_underrun got=%0d exp=%0d", und_cnt - u0, mdl_und - m0);
        end
        checks++; if (busy !== 1'b0 || miso !== 1'b0) begin
            failures++; $display("FAIL basic_idle busy=%b miso=%b exp 0 0", busy, miso);
        end
        rx_got.delete(); exp_rx.delete();
    endtask

    task automatic test_multi();
        logic [7:0] mo[3];
        logic [7:0] fv[3];
        logic [7:0] mi, e;
        int u0 = und_cnt, m0 = mdl_und;
        mo = '{8'h01, 8'h80, 8'hFF};
        fv = '{8'h11, 8'h22, 8'h33};
        wr_tx(fv[0]);
        cs_fall();
        e = mdl_load();
        for (int k = 0; k < 3; k++) begin
            spi_bits(8, mo[k], mi, (k < 2), (k < 2) ? fv[k+1] : 8'h00);
            checks++; if (mi !== e) begin failures++; $display("FAIL multi_miso byte=%0d got=%h exp=%h", k, mi, e); end
            exp_rx.push_back(mo[k]);
            e = mdl_load();
        end
        cs_rise();
        checks++;
        if (rx_got.size() != exp_rx.size()) begin
            failures++; $display("FAIL multi_rx_count got=%0d exp=%0d", rx_got.size(), exp_rx.size());
        end else begin
            foreach (exp_rx[k]) begin
                checks++;
                if (rx_got[k] !== exp_rx[k]) begin failures++; $display("FAIL multi_rx byte=%0d got=%h exp=%h", k, rx_got[k], exp_rx[k]); end
            end
        end
        checks++; if ((und_cnt - u0) != (mdl_und - m0)) begin
            failures++; $display("FAIL multi_underrun got=%0d exp=%0d", und_cnt - u0, mdl_und - m0);
        end
        rx_got.delete(); exp_rx.delete();
    endtask

    task automatic test_underrun();
        logic [7:0] mi, e, r;
        int u0 = und_cnt, m0 = mdl_und;
        r = 8'($urandom);
        cs_fall();
        e = mdl_load();
        spi_bits(8, r, mi, 1'b1, 8'($urandom));
        exp_rx.push_back(r);
        void'(mdl_load());
        cs_rise();
        checks++; if (mi !== e) begin failures++; $display("FAIL underrun_miso got=%h exp=%h", mi, e); end
        checks++; if ((und_cnt - u0) != (mdl_und - m0)) begin
            failures++; $display("FAIL underrun_pulses got=%0d exp=%0d", und_cnt - u0, mdl_und - m0);
        end
        checks++; if (rx_got.size() != 1 || rx_got[0] !== r) begin
            failures++; $display("FAIL underrun_rx count=%0d data=%h exp=%h", rx_got.size(), rx_data, r);
        end
        rx_got.delete(); exp_rx.delete();
    endtask

    task automatic test_partial();
        logic [7:0] mi, e, t;
        cs_fall();
        void'(mdl_load());
        spi_bits(5, 8'($urandom), mi, 1'b0, 8'h00);
        cs_rise();
        checks++; if (rx_got.size() != 0) begin
            failures++; $display("FAIL partial_no_rx got=%0d exp=0", rx_got.size());
        end
        t = 8'($urandom);
        wr_tx(t);
        cs_fall();
        e = mdl_load();
        spi_bits(8, 8'h96, mi, 1'b0, 8'h00);
        void'(mdl_load());
        cs_rise();
        checks++; if (mi !== e) begin failures++; $display("FAIL partial_next_miso got=%h exp=%h", mi, e); end
        checks++; if (rx_got.size() != 1 || rx_got[0] !== 8'h96) begin
            failures++; $display("FAIL partial_next_rx count=%0d data=%h exp=96", rx_got.size(), rx_data);
        end
        rx_got.delete(); exp_rx.delete();
    endtask

    task automatic test_reset_mid();
        logic [7:0] mi, e, r;
        wr_tx(8'($urandom));
        cs_fall();
        void'(mdl_load());
        spi_bits(4, 8'($urandom), mi, 1'b0, 8'h00);
        wr_tx(8'($urandom));
        reset = 1'b1;
        #1;
        checks++; if (miso !== 1'b0)     begin failures++; $display("FAIL rstmid_miso got=%b exp=0", miso); end
        checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL rstmid_rx_data got=%h exp=00", rx_data); end
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL rstmid_tx_ready got=%b exp=1", tx_ready); end
        checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        mdl_buf.delete(); rx_got.delete(); exp_rx.delete();
        @(negedge clk);
        cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        r = 8'($urandom);
        wr_tx(8'($urandom));
        cs_fall();
        e = mdl_load();
        spi_bits(8, r, mi, 1'b0, 8'h00);
        void'(mdl_load());
        cs_rise();
        checks++; if (mi !== e) begin failures++; $display("FAIL rstmid_next_miso got=%h exp=%h", mi, e); end
        checks++; if (rx_got.size() != 1 || rx_got[0] !== r) begin
            failures++; $display("FAIL rstmid_next_rx count=%0d data=%h exp=%h", rx_got.size(), rx_data, r);
        end
        rx_got.delete(); exp_rx.delete();
    endtask

    task automatic test_hold_valid();
        logic [7:0] a, b, c, mi, e;
        logic [7:0] r[3];
        int hi = 0;
        a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
        for (int k = 0; k < 3; k++) r[k] = 8'($urandom);
        tx_valid = 1'b1; tx_data = a;
        @(negedge clk);
        mdl_buf.push_back(a);
        tx_data = b;
        repeat (10) begin
            @(negedge clk);
            if (tx_ready !== 1'b0) hi++;
        end
        checks++; if (hi != 0) begin failures++; $display("FAIL hold_full_ready cycles_high=%0d exp=0", hi); end
        cs_fall();
        e = mdl_load();
        mdl_buf.push_back(b);
        tx_data = c;
        spi_bits(8, r[0], mi, 1'b0, 8'h00);
        checks++; if (mi !== e) begin failures++; $display("FAIL hold_miso0 got=%h exp=%h", mi, e); end
        e = mdl_load();
        mdl_buf.push_back(c);
        tx_valid = 1'b0;
        for (int k = 1; k < 3; k++) begin
            spi_bits(8, r[k], mi, 1'b0, 8'h00);
            checks++; if (mi !== e) begin failures++; $display("FAIL hold_miso byte=%0d got=%h exp=%h", k, mi, e); end
            e = mdl_load();
        end
        cs_rise();
        checks++; if (tx_ready !== (mdl_buf.size() == 0)) begin
            failures++; $display("FAIL hold_final_ready got=%b exp=%b", tx_ready, (mdl_buf.size() == 0));
        end
        checks++; if (rx_got.size() != 3 || rx_got[2] !== r[2]) begin
            failures++; $display("FAIL hold_rx count=%0d last=%h exp=%h", rx_got.size(), rx_data, r[2]);
        end
        rx_got.delete(); exp_rx.delete();
    endtask

    task automatic test_random();
        logic [7:0] mi, e, r;
        int nb;
        for (int t = 0; t < 6; t++) begin
            int u0 = und_cnt, m0 = mdl_und;
            nb = $urandom_range(1, 4);
            if ($urandom_range(0, 1) == 1) wr_tx(8'($urandom));
            cs_fall();
            e = mdl_load();
            for (int k = 0; k < nb; k++) begin
                r = 8'($urandom);
                spi_bits(8, r, mi, ($urandom_range(0, 2) != 0), 8'($urandom));
                checks++; if (mi !== e) begin failures++; $display("FAIL rand_miso xfer=%0d byte=%0d got=%h exp=%h", t, k, mi, e); end
                exp_rx.push_back(r);
                e = mdl_load();
            end
            cs_rise();
            checks++;
            if (rx_got.size() != exp_rx.size()) begin
                failures++; $display("FAIL rand_rx_count xfer=%0d got=%0d exp=%0d", t, rx_got.size(), exp_rx.size());
            end else begin
                foreach (exp_rx[k]) begin
                    checks++;
                    if (rx_got[k] !== exp_rx[k]) begin failures++; $display("FAIL rand_rx xfer=%0d byte=%0d got=%h exp=%h", t, k, rx_got[k], exp_rx[k]); end
                end
            end
            checks++; if ((und_cnt - u0) != (mdl_und - m0)) begin
                failures++; $display("FAIL rand_underrun xfer=%0d got=%0d exp=%0d", t, und_cnt - u0, mdl_und - m0);
            end
            rx_got.delete(); exp_rx.delete();
        end
        checks++; if (rx_long != 0) begin failures++; $display("FAIL rx_valid_width long_pulses=%0d exp=0", rx_long); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_multi();
        test_underrun();
        test_partial();
        test_reset_mid();
        test_hold_valid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
